// File: rtl/datapath_ctrl_pkg.sv
// Shared encodings for the datapath controller: opcodes, ALU ops, write-back selects, FSM states.
package datapath_ctrl_pkg;

  localparam logic [2:0] OpcMov = 3'b110;
  localparam logic [2:0] OpcAlu = 3'b101;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpCmp = 2'b01;
  localparam logic [1:0] OpAnd = 2'b10;
  localparam logic [1:0] OpMvn = 2'b11;

  localparam logic [1:0] VselC   = 2'b00;
  localparam logic [1:0] VselImm = 2'b10;

  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StGetA,
    StGetB,
    StAlu,
    StWrReg,
    StWrImm
  } state_e;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
  } instr_fields_t;

  typedef struct packed {
    logic       w;
    logic       err;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic [1:0] vsel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic logic is_cmp(instr_fields_t f);
    return (f.opcode == OpcAlu) && (f.op == OpCmp);
  endfunction

  // State reached from DECODE; StWait means the instruction is illegal.
  function automatic state_e decode_target(instr_fields_t f);
    state_e nxt;
    nxt = StWait;
    if (f.opcode == OpcMov) begin
      if (f.op == OpAnd)      nxt = StWrImm;
      else if (f.op == OpAdd) nxt = StGetB;
    end else if (f.opcode == OpcAlu) begin
      nxt = (f.op == OpMvn) ? StGetB : StGetA;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/datapath_ctrl_instr_dec.sv
// Combinational instruction field extraction and imm8 sign extension.
module instr_dec
  import datapath_ctrl_pkg::*;
(
  input  logic [15:0]   ir,
  output instr_fields_t fields,
  output logic [15:0]   sximm8
);

  always_comb begin
    fields.opcode = ir[15:13];
    fields.op     = ir[12:11];
    fields.rn     = ir[10:8];
    fields.rd     = ir[7:5];
    fields.sh     = ir[4:3];
    fields.rm     = ir[2:0];
  end

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle controller: latches an instruction in WAIT and sequences register-file/ALU strobes.
module datapath_ctrl
  import datapath_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s,
  input  logic [15:0] instr,
  output logic        w,
  output logic        err,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  aluop,
  output logic [15:0] sximm8
);

  state_e        state_q, state_d;
  logic [15:0]   ir_q, ir_d;
  instr_fields_t f_d;
  logic [15:0]   sximm8_d, sximm8_q;
  ctrl_t         ctrl_d, ctrl_q;

  // instr is only sampled on the accepting edge; afterwards the latch holds.
  assign ir_d = ((state_q == StWait) && s) ? instr : ir_q;

  instr_dec u_instr_dec (
    .ir    (ir_d),
    .fields(f_d),
    .sximm8(sximm8_d)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait:   if (s) state_d = StDecode;
      StDecode: state_d = decode_target(f_d);
      StGetA:   state_d = StGetB;
      StGetB:   state_d = StAlu;
      StAlu:    state_d = is_cmp(f_d) ? StWait : StWrReg;
      StWrReg:  state_d = StWait;
      StWrImm:  state_d = StWait;
      default:  state_d = StWait;
    endcase
  end

  // Outputs are the Moore decode of the next state/instruction, registered alongside them.
  always_comb begin
    ctrl_d       = '0;
    ctrl_d.shift = f_d.sh;
    ctrl_d.aluop = f_d.op;
    unique case (state_d)
      StWait:   ctrl_d.w = 1'b1;
      StDecode: ctrl_d.err = (decode_target(f_d) == StWait);
      StGetA: begin
        ctrl_d.readnum = f_d.rn;
        ctrl_d.loada   = 1'b1;
      end
      StGetB: begin
        ctrl_d.readnum = f_d.rm;
        ctrl_d.loadb   = 1'b1;
      end
      StAlu: begin
        ctrl_d.asel = (f_d.opcode == OpcMov);
        if (is_cmp(f_d)) ctrl_d.loads = 1'b1;
        else             ctrl_d.loadc = 1'b1;
      end
      StWrReg: begin
        ctrl_d.writenum = f_d.rd;
        ctrl_d.vsel     = VselC;
        ctrl_d.write    = 1'b1;
      end
      StWrImm: begin
        ctrl_d.writenum = f_d.rn;
        ctrl_d.vsel     = VselImm;
        ctrl_d.write    = 1'b1;
      end
      default: ctrl_d.w = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StWait;
      ir_q     <= '0;
      sximm8_q <= '0;
      ctrl_q   <= '0;
      ctrl_q.w <= 1'b1;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      sximm8_q <= sximm8_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign w        = ctrl_q.w;
  assign err      = ctrl_q.err;
  assign readnum  = ctrl_q.readnum;
  assign writenum = ctrl_q.writenum;
  assign write    = ctrl_q.write;
  assign loada    = ctrl_q.loada;
  assign loadb    = ctrl_q.loadb;
  assign loadc    = ctrl_q.loadc;
  assign loads    = ctrl_q.loads;
  assign asel     = ctrl_q.asel;
  assign vsel     = ctrl_q.vsel;
  assign shift    = ctrl_q.shift;
  assign aluop    = ctrl_q.aluop;
  assign sximm8   = sximm8_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed bench for datapath_ctrl with hand-computed sequences per instruction class.
module tb_datapath_ctrl;

  logic        clk;
  logic        rst_n;
  logic        s;
  logic [15:0] instr;
  logic        w, err, write, loada, loadb, loadc, loads, asel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, aluop;
  logic [15:0] sximm8;

  int n_checks = 0;
  int n_fail   = 0;

  // {w, err, write, loada, loadb, loadc, loads, asel}
  logic [7:0] strb;
  assign strb = {w, err, write, loada, loadb, loadc, loads, asel};

  datapath_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s       (s),
    .instr   (instr),
    .w       (w),
    .err     (err),
    .readnum (readnum),
    .writenum(writenum),
    .write   (write),
    .loada   (loada),
    .loadb   (loadb),
    .loadc   (loadc),
    .loads   (loads),
    .asel    (asel),
    .vsel    (vsel),
    .shift   (shift),
    .aluop   (aluop),
    .sximm8  (sximm8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (strb !== 8'b1000_0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected %b", strb, 8'b1000_0000);
    end
    n_checks++;
    if ({readnum, writenum, vsel, shift, aluop, sximm8} !== 28'h0) begin
      n_fail++;
      $display("FAIL reset_fields: got %h expected 0", {readnum, writenum, vsel, shift, aluop, sximm8});
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_mov_imm();
    instr = 16'hD3FB; s = 1'b1;
    tick();
    s = 1'b0;
    n_checks++;
    if (strb !== 8'b0000_0000) begin
      n_fail++; $display("FAIL movimm_decode: got %b expected %b", strb, 8'b0);
    end
    tick();
    n_checks++;
    if ({strb, writenum, vsel, sximm8} !== {8'b0010_0000, 3'd3, 2'b10, 16'hFFFB}) begin
      n_fail++;
      $display("FAIL movimm_write: got %b/%0d/%b/%h expected 00100000/3/10/fffb",
               strb, writenum, vsel, sximm8);
    end
    tick();
    n_checks++;
    if (strb !== 8'b1000_0000) begin
      n_fail++; $display("FAIL movimm_done: got %b expected %b", strb, 8'b1000_0000);
    end
  endtask

  task automatic test_add();
    instr = 16'hA140; s = 1'b1;
    tick();
    s = 1'b0;
    n_checks++;
    if (strb !== 8'b0000_0000) begin
      n_fail++; $display("FAIL add_decode: got %b expected 0", strb);
    end
    tick();
    n_checks++;
    if ({strb, readnum} !== {8'b0001_0000, 3'd1}) begin
      n_fail++; $display("FAIL add_geta: got %b/%0d expected 00010000/1", strb, readnum);
    end
    tick();
    n_checks++;
    if ({strb, readnum} !== {8'b0000_1000, 3'd0}) begin
      n_fail++; $display("FAIL add_getb: got %b/%0d expected 00001000/0", strb, readnum);
    end
    tick();
    n_checks++;
    if ({strb, aluop} !== {8'b0000_0100, 2'b00}) begin
      n_fail++; $display("FAIL add_alu: got %b/%b expected 00000100/00", strb, aluop);
    end
    tick();
    n_checks++;
    if ({strb, writenum, vsel} !== {8'b0010_0000, 3'd2, 2'b00}) begin
      n_fail++;
      $display("FAIL add_wrreg: got %b/%0d/%b expected 00100000/2/00", strb, writenum, vsel);
    end
    tick();
    n_checks++;
    if (strb !== 8'b1000_0000) begin
      n_fail++; $display("FAIL add_done: got %b expected 10000000", strb);
    end
  endtask

  task automatic test_cmp();
    logic [7:0] exp_seq [4];
    exp_seq = '{8'b0000_0000, 8'b0001_0000, 8'b0000_1000, 8'b0000_0010};
    instr = 16'hA900; s = 1'b1;
    tick();
    s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (strb !== exp_seq[i]) begin
        n_fail++; $display("FAIL cmp_step%0d: got %b expected %b", i, strb, exp_seq[i]);
      end
      if (i < 3) tick();
    end
    n_checks++;
    if (aluop !== 2'b01) begin
      n_fail++; $display("FAIL cmp_aluop: got %b expected 01", aluop);
    end
    tick();
    n_checks++;
    if (strb !== 8'b1000_0000) begin
      n_fail++; $display("FAIL cmp_done: got %b expected 10000000", strb);
    end
  endtask

  task automatic test_mov_reg_mvn();
    // MOV R1,R2: 4 cycles to write, A operand zeroed
    instr = 16'hC022; s = 1'b1;
    tick();
    s = 1'b0;
    tick();
    n_checks++;
    if ({strb, readnum} !== {8'b0000_1000, 3'd2}) begin
      n_fail++; $display("FAIL movreg_getb: got %b/%0d expected 00001000/2", strb, readnum);
    end
    tick();
    n_checks++;
    if (strb !== 8'b0000_0101) begin
      n_fail++; $display("FAIL movreg_alu: got %b expected 00000101", strb);
    end
    tick();
    n_checks++;
    if ({strb, writenum} !== {8'b0010_0000, 3'd1}) begin
      n_fail++; $display("FAIL movreg_wr: got %b/%0d expected 00100000/1", strb, writenum);
    end
    tick();
    // MVN R5,R3 with sh=01
    instr = 16'hB8AB; s = 1'b1;
    tick();
    s = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({strb, shift, aluop} !== {8'b0000_0100, 2'b01, 2'b11}) begin
      n_fail++;
      $display("FAIL mvn_alu: got %b/%b/%b expected 00000100/01/11", strb, shift, aluop);
    end
    tick();
    n_checks++;
    if ({strb, writenum} !== {8'b0010_0000, 3'd5}) begin
      n_fail++; $display("FAIL mvn_wr: got %b/%0d expected 00100000/5", strb, writenum);
    end
    tick();
  endtask

  task automatic test_illegal();
    instr = 16'hE000; s = 1'b1;
    tick();
    s = 1'b0;
    n_checks++;
    if (strb !== 8'b0100_0000) begin
      n_fail++; $display("FAIL illegal_err: got %b expected 01000000", strb);
    end
    tick();
    n_checks++;
    if (strb !== 8'b1000_0000) begin
      n_fail++; $display("FAIL illegal_wait: got %b expected 10000000", strb);
    end
  endtask

  task automatic test_reset_mid();
    instr = 16'hA140; s = 1'b1;
    tick();
    s = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({strb, readnum, writenum, vsel, shift, aluop, sximm8} !== {8'b1000_0000, 28'h0}) begin
      n_fail++;
      $display("FAIL midreset_async: got %b/%h expected 10000000/0",
               strb, {readnum, writenum, vsel, shift, aluop, sximm8});
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (strb !== 8'b1000_0000) begin
        n_fail++; $display("FAIL midreset_idle%0d: got %b expected 10000000", i, strb);
      end
    end
    instr = 16'hD3FB; s = 1'b1;
    tick();
    s = 1'b0;
    tick();
    n_checks++;
    if ({write, writenum, sximm8} !== {1'b1, 3'd3, 16'hFFFB}) begin
      n_fail++;
      $display("FAIL midreset_mov: got %b/%0d/%h expected 1/3/fffb", write, writenum, sximm8);
    end
    tick();
  endtask

  task automatic test_instr_change();
    instr = 16'hA140; s = 1'b1;
    tick();
    s = 1'b0;
    tick();
    instr = 16'hA7E0;
    tick();
    n_checks++;
    if (readnum !== 3'd0) begin
      n_fail++; $display("FAIL change_getb: got readnum %0d expected 0", readnum);
    end
    tick();
    tick();
    n_checks++;
    if ({write, writenum} !== {1'b1, 3'd2}) begin
      n_fail++; $display("FAIL change_wr: got %b/%0d expected 1/2", write, writenum);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    instr = 16'hD3FB; s = 1'b1;
    tick();
    tick();
    n_checks++;
    if (write !== 1'b1) begin
      n_fail++; $display("FAIL b2b_write1: got %b expected 1", write);
    end
    tick();
    n_checks++;
    if (w !== 1'b1) begin
      n_fail++; $display("FAIL b2b_wait: got %b expected 1", w);
    end
    tick();
    n_checks++;
    if ({w, err, write} !== 3'b000) begin
      n_fail++; $display("FAIL b2b_decode: got %b expected 000", {w, err, write});
    end
    tick();
    s = 1'b0;
    n_checks++;
    if ({write, writenum} !== {1'b1, 3'd3}) begin
      n_fail++; $display("FAIL b2b_write2: got %b/%0d expected 1/3", write, writenum);
    end
    tick();
    n_checks++;
    if (strb !== 8'b1000_0000) begin
      n_fail++; $display("FAIL b2b_done: got %b expected 10000000", strb);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    s     = 1'b0;
    instr = 16'h0000;
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_mov_reg_mvn();
    test_illegal();
    test_reset_mid();
    test_instr_change();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
